// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address
// and registers instruction/address pairs into the IF/ID boundary.
module if_fetch_stage #(
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter logic [15:0] NOP_INSTR   = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    output logic [15:0] instruc_out,
    output logic [7:0]  addr_out,
    output logic        valid_out,
    output logic [7:0]  pc_out,
    output logic        halted
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  addr_q, addr_d;
    logic        valid_q, valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            addr_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    pc_d    = branch_target;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (flush) begin
                    // PC is left alone so the discarded address is fetched again
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d = imem_data;
                    addr_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 8'd1;
                    if (imem_data[15:12] == HALT_OPCODE)
                        state_d = HALT;
                end
            end
            HALT: begin
                // Only an older branch can cancel the speculatively fetched HALT
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                if (branch_taken) begin
                    pc_d    = branch_target;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign instruc_out = instr_q;
    assign addr_out    = addr_q;
    assign valid_out   = valid_q;
    assign halted      = (state_q == HALT);

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage; producer side of the IF/ID interface.
- Holds the 8-bit PC and drives the instruction memory address.
- Registers the fetched 16-bit instruction and its address into the IF/ID boundary each cycle.
- Handles stall, flush, branch redirect and HALT-opcode detection so the downstream IF/ID buffer sees only clean instruction/address pairs.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- NOP_INSTR, 16'h0000, bubble pattern driven on instruc_out when no valid instruction.
- HALT_OPCODE, 4'hF, value of instruction bits [15:12] that stops fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  8  instruction memory address; combinational copy of PC.
- imem_data  in  16  instruction memory read data; combinational, valid in the same cycle as imem_addr.
- stall  in  1  hazard unit hold request.
- flush  in  1  discard the instruction entering IF/ID.
- branch_taken  in  1  redirect request from a later stage.
- branch_target  in  8  redirect address, sampled when branch_taken=1.
- instruc_out  out  16  registered instruction to IF/ID.
- addr_out  out  8  registered address of instruc_out.
- valid_out  out  1  instruc_out holds a real instruction.
- pc_out  out  8  current PC, debug only.
- halted  out  1  fetch is in HALT state.

Behaviour:
- Reset is asynchronous and active-high on rst. One clock, clk.
- Reset values:
  - pc = RESET_PC
  - instruc_out = NOP_INSTR
  - addr_out = 8'h00
  - valid_out = 0
  - halted = 0
  - state = RUN
- Assertion of rst mid-operation takes effect immediately, regardless of clk.
- imem_addr = pc at all times, including in HALT.
- States:
  - RUN: normal fetch.
  - HALT: fetch stopped.
- Per-edge priority: branch_taken > flush > stall > normal.
- RUN, branch_taken=1:
  - pc <= branch_target
  - instruc_out <= NOP_INSTR, valid_out <= 0
  - addr_out unchanged
  - stall and flush are ignored this cycle.
- RUN, flush=1 (no branch):
  - instruc_out <= NOP_INSTR, valid_out <= 0
  - pc unchanged, so the same address is re-fetched next cycle.
- RUN, stall=1 (no branch, no flush): pc, instruc_out, addr_out and valid_out all hold.
- RUN, normal:
  - instruc_out <= imem_data, addr_out <= pc, valid_out <= 1
  - pc <= pc + 1, modulo 256 (8'hFF wraps to 8'h00, no flag).
- HALT detection: on a normal RUN load where imem_data[15:12] == HALT_OPCODE:
  - The HALT instruction itself is passed with valid_out=1.
  - pc <= pc + 1.
  - Next state HALT, halted <= 1 on the same edge.
- HALT, every edge:
  - instruc_out <= NOP_INSTR, valid_out <= 0
  - pc holds.
- HALT exits only on branch_taken=1:
  - The older branch cancels the speculatively fetched HALT.
  - pc <= branch_target, state <= RUN, halted <= 0, output is a NOP bubble.
  - stall and flush in HALT are otherwise no-ops.
- A HALT opcode arriving while stalled, flushed or redirected is not detected; detection happens only on a normal load.
- Latency:
  - Address to instruc_out: 1 cycle.
  - Redirect to first target instruction on instruc_out: 2 edges (bubble, then target).
- valid_out=0 always coincides with instruc_out == NOP_INSTR.

Test Plan:
1. Reset then run; imem returns 16'h1000+addr -> after edges 1..3, instruc_out = 16'h1000/1001/1002, addr_out = 00/01/02, valid_out = 1, pc_out = 03.
2. stall held 2 cycles at pc=05 -> instruc_out/addr_out/pc frozen for 2 edges. Stall together with branch_taken (target 8'h40) -> bubble, pc = 40.
3. flush at pc=07 -> NOP with valid 0, pc stays 07. Next edge: addr_out = 07 with that address's data.
4. PC wraps: preset via branch to 8'hFE, run 3 edges -> addr_out sequence FE, FF, 00, no glitch in valid.
5. imem returns 16'hF000 at addr 0A -> instruc_out = F000 with valid 1, then halted = 1, NOPs with pc = 0B held for 4 cycles. Then branch_taken to 8'h20 -> halted 0, next valid addr_out = 20.
6. rst asserted between edges mid-run with valid_out = 1 -> outputs go to reset values immediately, without a clock edge.
